dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single 32×8 data memory (`datamem`) between the CPU data port (m0) and a host/debug loader port (m1). Each requester issues one read or write at a time over a req/ack handshake. The arbiter serialises the accesses and drives the memory's `rd`/`wr`/`addr`/`in` pins from registers. It returns read data through per-port registers, so the memory sees at most one access per cycle.

---
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-ported 32x8 data memory between the CPU data port (m0)
// and a host/debug loader port (m1). Each access takes three cycles:
// IDLE (arbitrate and latch), ACCESS (memory pins driven from registers),
// RESP (one-cycle ack to the winner).
//
// Build option:
//   DMEM_ARBITER_FIXED_PRIO_EN  - when defined, m0 always wins simultaneous
//                                 requests and no round-robin state exists.
//                                 When undefined, ties alternate via last_grant.
module dmem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [7:0]    conflicts
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          grant_reg, grant_next;       // 0 = m0 owns the access, 1 = m1
    logic          mem_rd_reg, mem_rd_next;
    logic          mem_wr_reg, mem_wr_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_din_reg, mem_din_next;
    logic [7:0]    conflicts_reg, conflicts_next;

    logic          both_req;
    logic          any_req;
    logic          pick_m1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign both_req = m0_req & m1_req;
    assign any_req  = m0_req | m1_req;

`ifdef DMEM_ARBITER_FIXED_PRIO_EN
    // m1 only wins when the CPU is not asking.
    assign pick_m1 = ~m0_req;
`else
    logic last_grant_reg, last_grant_next;

    // On a tie the port that did not win last time is served.
    assign pick_m1 = both_req ? ~last_grant_reg : m1_req;

    // Remember the winner each time an access is launched.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (state_reg == IDLE && any_req) begin
            last_grant_next = pick_m1;
        end
    end

    // Round-robin history; starts at m1 so m0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`endif

    // Request fields of whichever port is being granted.
    assign sel_we    = pick_m1 ? m1_we    : m0_we;
    assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;

    // Next-state and next memory-pin values; memory pins only change on edges.
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        mem_rd_next    = mem_rd_reg;
        mem_wr_next    = mem_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_din_next   = mem_din_reg;
        conflicts_next = conflicts_reg;
        case (state_reg)
            IDLE: begin
                if (both_req && conflicts_reg != 8'hFF) begin
                    conflicts_next = conflicts_reg + 8'd1;
                end
                if (any_req) begin
                    state_next    = ACCESS;
                    grant_next    = pick_m1;
                    mem_rd_next   = ~sel_we;
                    mem_wr_next   = sel_we;
                    mem_addr_next = sel_addr;
                    mem_din_next  = sel_wdata;
                end
            end
            ACCESS: begin
                state_next  = RESP;
                mem_rd_next = 1'b0;
                mem_wr_next = 1'b0;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                mem_rd_next = 1'b0;
                mem_wr_next = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= 1'b0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
            conflicts_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            mem_rd_reg    <= mem_rd_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
            conflicts_reg <= conflicts_next;
        end
    end

    logic [1:0]         ack_bus;
    logic [1:0][DW-1:0] rdata_bus;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic          serve;
        logic          ack_reg;
        logic [DW-1:0] rdata_reg;

        assign serve = (state_reg == ACCESS) && (grant_reg == (gi == 1));

        // Ack pulses in the cycle after this port's access; read data is held
        // until this port's next read completes.
        always_ff @(posedge clk) begin
            if (rst) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= serve;
                if (serve && mem_rd_reg) begin
                    rdata_reg <= mem_dout;
                end
            end
        end

        assign ack_bus[gi]   = ack_reg;
        assign rdata_bus[gi] = rdata_reg;
    end

    assign m0_ack    = ack_bus[0];
    assign m1_ack    = ack_bus[1];
    assign m0_rdata  = rdata_bus[0];
    assign m1_rdata  = rdata_bus[1];
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_din   = mem_din_reg;
    assign conflicts = conflicts_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural 32x8
// memory (combinational read, write on the rising edge).
module tb_dmem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [7:0]    conflicts;

    int checks = 0;
    int errors = 0;
    int grant_log[$];
    int cyc_log[$];

    logic [DW-1:0] mem_model [32];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .conflicts(conflicts)
    );

    always @(posedge clk) begin
        if (mem_wr) mem_model[mem_addr] <= mem_din;
    end
    assign mem_dout = mem_model[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on one port; returns cycles from first sampling edge to ack.
    task automatic do_single(input int port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output int lat,
                             output logic [DW-1:0] rd, output logic ack_after);
        lat = -1;
        rd  = '0;
        if (port == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            if ((port == 0) ? m0_ack : m1_ack) begin
                lat = c;
                rd  = (port == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        ack_after = (port == 0) ? m0_ack : m1_ack;
        $display("txn port=%0d we=%0d addr=%0d wdata=%02h lat=%0d rdata=%02h",
                 port, we, addr, wdata, lat, rd);
    endtask

    // Both ports read continuously; winner drops req on ack, re-raises next cycle.
    task automatic run_continuous(input int n);
        int c;
        c = 0;
        grant_log.delete();
        cyc_log.delete();
        m0_we = 1'b0; m0_addr = 5'd3; m1_we = 1'b0; m1_addr = 5'd7;
        m0_req = 1'b1; m1_req = 1'b1;
        while (grant_log.size() < n && c < n * 3 + 20) begin
            tick();
            c++;
            if (m0_ack) begin
                grant_log.push_back(0); cyc_log.push_back(c); m0_req = 1'b0;
                $display("txn port=0 cyc=%0d rdata=%02h conflicts=%0d", c, m0_rdata, conflicts);
            end else if (!m0_req) begin
                m0_req = 1'b1;
            end
            if (m1_ack) begin
                grant_log.push_back(1); cyc_log.push_back(c); m1_req = 1'b0;
                $display("txn port=1 cyc=%0d rdata=%02h conflicts=%0d", c, m1_rdata, conflicts);
            end else if (!m1_req) begin
                m1_req = 1'b1;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_rd_wr got %b want 00", {mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        checks++; if (mem_din !== 8'd0) begin errors++; $display("FAIL reset_din got %02h want 00", mem_din); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b want 00", {m0_ack, m1_ack}); end
        checks++; if (m0_rdata !== 8'd0 || m1_rdata !== 8'd0) begin errors++; $display("FAIL reset_rdata got %02h/%02h want 00/00", m0_rdata, m1_rdata); end
        checks++; if (conflicts !== 8'd0) begin errors++; $display("FAIL reset_conflicts got %0d want 0", conflicts); end
        $display("txn reset");
    endtask

    task automatic test_reset_mid_access();
        m0_we = 1'b0; m0_addr = 5'd5; m0_req = 1'b1;
        tick();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 5'd5) begin errors++; $display("FAIL midrst_access got rd=%b addr=%0d want rd=1 addr=5", mem_rd, mem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b0;
        checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b want 0", m0_ack); end
        checks++; if (m0_rdata !== 8'd0) begin errors++; $display("FAIL midrst_rdata got %02h want 00", m0_rdata); end
        checks++; if ({mem_rd, mem_wr, mem_addr, mem_din} !== 15'd0) begin errors++; $display("FAIL midrst_mem got rd=%b wr=%b addr=%0d din=%02h want zeros", mem_rd, mem_wr, mem_addr, mem_din); end
        tick();
        checks++; if (m0_ack !== 1'b0 || m0_rdata !== 8'd0) begin errors++; $display("FAIL midrst_late_ack got ack=%b rdata=%02h want 0/00", m0_ack, m0_rdata); end
        $display("txn reset during m0 read access");
    endtask

    task automatic test_m1_write_read();
        int lat;
        logic [DW-1:0] rd;
        logic aa;
        m1_we = 1'b1; m1_addr = 5'd3; m1_wdata = 8'hA5; m1_req = 1'b1;
        tick();
        checks++; if ({mem_wr, mem_rd} !== 2'b10 || mem_addr !== 5'd3 || mem_din !== 8'hA5) begin errors++; $display("FAIL m1w_access got wr=%b rd=%b addr=%0d din=%02h want 1 0 3 a5", mem_wr, mem_rd, mem_addr, mem_din); end
        tick();
        checks++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL m1w_ack got m1=%b m0=%b want 1 0", m1_ack, m0_ack); end
        m1_req = 1'b0;
        tick();
        checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL m1w_ack_pulse got %b want 0", m1_ack); end
        $display("txn port=1 we=1 addr=3 wdata=a5");
        do_single(1, 1'b0, 5'd3, 8'h00, lat, rd, aa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL m1r_latency got %0d want 2", lat); end
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL m1r_rdata got %02h want a5", rd); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL m1r_ack_pulse got %b want 0", aa); end
    endtask

    task automatic test_contention();
        int t0, t1;
        logic [DW-1:0] r1;
        logic [7:0] c0;
        t0 = -1; t1 = -1; r1 = '0;
        c0 = conflicts;
        m0_we = 1'b1; m0_addr = 5'd7; m0_wdata = 8'h11;
        m1_we = 1'b0; m1_addr = 5'd7;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (m0_ack) begin t0 = c; m0_req = 1'b0; end
            if (m1_ack) begin t1 = c; r1 = m1_rdata; m1_req = 1'b0; end
            if (t0 > 0 && t1 > 0) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        $display("txn contention m0_ack@%0d m1_ack@%0d m1_rdata=%02h", t0, t1, r1);
        checks++; if (t0 !== 2) begin errors++; $display("FAIL cont_m0_ack got %0d want 2", t0); end
        checks++; if (t1 !== 5) begin errors++; $display("FAIL cont_m1_ack got %0d want 5", t1); end
        checks++; if (r1 !== 8'h11) begin errors++; $display("FAIL cont_m1_rdata got %02h want 11", r1); end
        checks++; if (conflicts !== c0 + 8'd1) begin errors++; $display("FAIL cont_conflicts got %0d want %0d", conflicts, c0 + 8'd1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c0;
        int exp_g;
        c0 = conflicts;
        run_continuous(12);
        checks++; if (grant_log.size() !== 12) begin errors++; $display("FAIL b2b_count got %0d want 12", grant_log.size()); end
        for (int i = 0; i < grant_log.size(); i++) begin
`ifdef DMEM_ARBITER_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            checks++; if (grant_log[i] !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d] got %0d want %0d", i, grant_log[i], exp_g); end
            if (i > 0) begin
                checks++; if (cyc_log[i] - cyc_log[i-1] !== 3) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", i, cyc_log[i] - cyc_log[i-1]); end
            end
        end
        checks++; if (conflicts !== c0 + 8'd12) begin errors++; $display("FAIL b2b_conflicts got %0d want %0d", conflicts, c0 + 8'd12); end
        checks++; if (m0_rdata !== 8'hA5) begin errors++; $display("FAIL b2b_m0_rdata got %02h want a5", m0_rdata); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [DW-1:0] rd;
        logic aa;
        do_single(0, 1'b1, 5'd31, 8'hFF, lat, rd, aa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wrap_w_latency got %0d want 2", lat); end
        do_single(0, 1'b0, 5'd31, 8'h00, lat, rd, aa);
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL wrap_r31 got %02h want ff", rd); end
        do_single(0, 1'b0, 5'd0, 8'h00, lat, rd, aa);
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL wrap_r0 got %02h want 5a", rd); end
        checks++; if (m1_rdata !== 8'h11) begin errors++; $display("FAIL m1_rdata_hold got %02h want 11", m1_rdata); end
    endtask

    task automatic test_saturation();
        run_continuous(300);
        checks++; if (grant_log.size() !== 300) begin errors++; $display("FAIL sat_count got %0d want 300", grant_log.size()); end
        checks++; if (conflicts !== 8'd255) begin errors++; $display("FAIL sat_conflicts got %0d want 255", conflicts); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_model[i] = 8'(i) ^ 8'h5A;
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_reset_mid_access();
        test_m1_write_read();
        test_contention();
        test_back_to_back();
        test_wrap();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
